// File: rtl/fir_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fir_stream_ctrl
//  Purpose  : Stream controller around one FIR filter instance. Accepts
//             samples over a ready/valid upstream port, issues them to the
//             filter one cycle later, captures filter results into a
//             show-ahead output FIFO and presents that FIFO downstream as
//             ready/valid. The filter cannot stall, so a sample is accepted
//             only when its result is guaranteed a FIFO slot
//             (inflight + fifo_count < FIFO_DEPTH). Also sequences the
//             filter reset after power-up and runs a flush that pushes
//             NUM_TAPS zeros through the delay line.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n            clock, asynchronous active-low reset
//    flush_req             single-cycle flush request (honoured in RUN only)
//    busy                  high while in INIT, FLUSH or DRAIN
//    s_valid/s_ready/s_data      upstream sample stream
//    m_valid/m_ready/m_data      downstream result stream (FIFO head)
//    fir_rst               filter reset, active-high
//    fir_valid_in/fir_din  filter input strobe and sample (registered)
//    fir_valid_out/fir_dout      filter result strobe and data
//    overflow_err          sticky: result with nothing in flight or no room
//    stat_in_cnt/stat_out_cnt    accept/pop counters (see below)
// ----------------------------------------------------------------------------
//  Build option
//    FIR_STREAM_STATS_EN : when defined, stat_in_cnt counts upstream accepts
//                          and stat_out_cnt counts downstream pops (both
//                          32-bit, wrapping). When undefined both ports are
//                          tied to zero and no counter logic exists.
// ============================================================================
module fir_stream_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int OUT_WIDTH   = 26,
  parameter int NUM_TAPS    = 37,
  parameter int FIR_LATENCY = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int RST_CYCLES  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_req,
  output logic                  busy,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_WIDTH-1:0]  m_data,
  output logic                  fir_rst,
  output logic                  fir_valid_in,
  output logic [DATA_WIDTH-1:0] fir_din,
  input  logic                  fir_valid_out,
  input  logic [OUT_WIDTH-1:0]  fir_dout,
  output logic                  overflow_err,
  output logic [31:0]           stat_in_cnt,
  output logic [31:0]           stat_out_cnt
);

  // --------------------------------------------------------------------------
  // Widths and constants
  // --------------------------------------------------------------------------
  localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_sum_w = c_cnt_w + 1;
  localparam int c_rst_w = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int c_tap_w = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

  localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_sum_w-1:0] c_depth_sum = c_sum_w'(FIFO_DEPTH);
  localparam logic [c_rst_w-1:0] c_rst_last  = c_rst_w'(RST_CYCLES - 1);
  localparam logic [c_tap_w-1:0] c_tap_last  = c_tap_w'(NUM_TAPS - 1);

  generate
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
        (FIR_LATENCY < 1) || (RST_CYCLES < 1) || (NUM_TAPS < 1)) begin : g_cfg_check
      $error("fir_stream_ctrl: illegal parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                  state_q,        state_d;
  logic [c_rst_w-1:0]      rst_cnt_q,      rst_cnt_d;
  logic [c_tap_w-1:0]      tap_cnt_q,      tap_cnt_d;
  logic [c_cnt_w-1:0]      inflight_q,     inflight_d;
  logic [c_cnt_w-1:0]      fifo_count_q,   fifo_count_d;
  logic [c_ptr_w-1:0]      wr_ptr_q,       wr_ptr_d;
  logic [c_ptr_w-1:0]      rd_ptr_q,       rd_ptr_d;
  logic [OUT_WIDTH-1:0]    mem_q [FIFO_DEPTH];
  logic [OUT_WIDTH-1:0]    mem_d [FIFO_DEPTH];
  logic                    fir_valid_in_q, fir_valid_in_d;
  logic [DATA_WIDTH-1:0]   fir_din_q,      fir_din_d;
  logic                    overflow_err_q, overflow_err_d;

  // --------------------------------------------------------------------------
  // Handshake / credit decode
  // --------------------------------------------------------------------------
  logic credit_ok;
  logic fifo_empty;
  logic fifo_full;
  logic accept;
  logic flush_issue;
  logic issue;
  logic pop;
  logic push;
  logic inflight_nz;
  logic capture;
  logic err_evt;

  always_comb begin
    // Credit counts every result that may still land in the FIFO, so an
    // accepted sample always has a slot regardless of filter latency.
    credit_ok   = ({1'b0, inflight_q} + {1'b0, fifo_count_q}) < c_depth_sum;
    fifo_empty  = (fifo_count_q == '0);
    fifo_full   = (fifo_count_q == c_depth_cnt);
    s_ready     = (state_q == ST_RUN) && credit_ok;
    accept      = s_valid && s_ready;
    // FLUSH is left on the cycle the last zero issues, so the tap counter
    // never has to gate this term.
    flush_issue = (state_q == ST_FLUSH) && credit_ok;
    issue       = accept || flush_issue;
    pop         = !fifo_empty && m_ready;
    inflight_nz = (inflight_q != '0);
    // A result is only legitimate if something is in flight; it is stored
    // only if a slot exists after this cycle's pop.
    capture     = fir_valid_out && inflight_nz;
    push        = capture && (!fifo_full || pop);
    err_evt     = fir_valid_out && (!inflight_nz || (fifo_full && !pop));
  end

  // --------------------------------------------------------------------------
  // FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    tap_cnt_d = tap_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (rst_cnt_q == c_rst_last) begin
          state_d = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + c_rst_w'(1);
        end
      end
      ST_RUN: begin
        if (flush_req) begin
          state_d   = ST_FLUSH;
          tap_cnt_d = '0;
        end
      end
      ST_FLUSH: begin
        if (flush_issue) begin
          if (tap_cnt_q == c_tap_last) begin
            state_d = ST_DRAIN;
          end else begin
            tap_cnt_d = tap_cnt_q + c_tap_w'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!inflight_nz) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next state
  // --------------------------------------------------------------------------
  always_comb begin
    fir_valid_in_d = issue;
    fir_din_d      = fir_din_q;
    if (accept) begin
      fir_din_d = s_data;
    end else if (flush_issue) begin
      fir_din_d = '0;
    end

    // Issue and capture in the same cycle cancel out.
    inflight_d = inflight_q;
    case ({issue, capture})
      2'b10:   inflight_d = inflight_q + c_cnt_w'(1);
      2'b01:   inflight_d = inflight_q - c_cnt_w'(1);
      default: inflight_d = inflight_q;
    endcase

    fifo_count_d = fifo_count_q;
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + c_cnt_w'(1);
      2'b01:   fifo_count_d = fifo_count_q - c_cnt_w'(1);
      default: fifo_count_d = fifo_count_q;
    endcase

    // Depth is a power of two, so pointers wrap naturally. When full with a
    // simultaneous pop, wr_ptr == rd_ptr and the write reuses the slot being
    // popped; m_data was already read from it this cycle.
    wr_ptr_d = push ? (wr_ptr_q + c_ptr_w'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + c_ptr_w'(1)) : rd_ptr_q;

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = fir_dout;
    end

    overflow_err_d = overflow_err_q || err_evt;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_INIT;
      rst_cnt_q      <= '0;
      tap_cnt_q      <= '0;
      inflight_q     <= '0;
      fifo_count_q   <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fir_valid_in_q <= 1'b0;
      fir_din_q      <= '0;
      overflow_err_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      rst_cnt_q      <= rst_cnt_d;
      tap_cnt_q      <= tap_cnt_d;
      inflight_q     <= inflight_d;
      fifo_count_q   <= fifo_count_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fir_valid_in_q <= fir_valid_in_d;
      fir_din_q      <= fir_din_d;
      overflow_err_q <= overflow_err_d;
      mem_q          <= mem_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy         = (state_q != ST_RUN);
  assign fir_rst      = (state_q == ST_INIT);
  assign fir_valid_in = fir_valid_in_q;
  assign fir_din      = fir_din_q;
  assign m_valid      = !fifo_empty;
  assign m_data       = mem_q[rd_ptr_q];
  assign overflow_err = overflow_err_q;

  // --------------------------------------------------------------------------
  // Optional statistics
  // --------------------------------------------------------------------------
`ifdef FIR_STREAM_STATS_EN
  logic [31:0] stat_in_q,  stat_in_d;
  logic [31:0] stat_out_q, stat_out_d;

  always_comb begin
    stat_in_d  = accept ? (stat_in_q  + 32'd1) : stat_in_q;
    stat_out_d = pop    ? (stat_out_q + 32'd1) : stat_out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_in_q  <= '0;
      stat_out_q <= '0;
    end else begin
      stat_in_q  <= stat_in_d;
      stat_out_q <= stat_out_d;
    end
  end

  assign stat_in_cnt  = stat_in_q;
  assign stat_out_cnt = stat_out_q;
`else
  assign stat_in_cnt  = '0;
  assign stat_out_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_stream_ctrl
//  Purpose  : Self-checking bench for fir_stream_ctrl. A behavioural filter
//             (fixed latency, out = 3*in + 1) sits on the fir_* ports. Each
//             accepted sample and each expected flush zero pushes its result
//             into a scoreboard queue; every downstream pop is compared
//             against the queue head.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fir_stream_ctrl;

  localparam int DW    = 16;
  localparam int OW    = 26;
  localparam int TAPS  = 37;
  localparam int LAT   = 8;
  localparam int DEPTH = 16;
  localparam int RSTC  = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          flush_req;
  logic          busy;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [OW-1:0] m_data;
  logic          fir_rst;
  logic          fir_valid_in;
  logic [DW-1:0] fir_din;
  logic          fir_valid_out;
  logic [OW-1:0] fir_dout;
  logic          overflow_err;
  logic [31:0]   stat_in_cnt;
  logic [31:0]   stat_out_cnt;
  logic          force_vo;

  fir_stream_ctrl #(
    .DATA_WIDTH (DW),
    .OUT_WIDTH  (OW),
    .NUM_TAPS   (TAPS),
    .FIR_LATENCY(LAT),
    .FIFO_DEPTH (DEPTH),
    .RST_CYCLES (RSTC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_req    (flush_req),
    .busy         (busy),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .fir_rst      (fir_rst),
    .fir_valid_in (fir_valid_in),
    .fir_din      (fir_din),
    .fir_valid_out(fir_valid_out),
    .fir_dout     (fir_dout),
    .overflow_err (overflow_err),
    .stat_in_cnt  (stat_in_cnt),
    .stat_out_cnt (stat_out_cnt)
  );

  function automatic logic [OW-1:0] f(input logic [DW-1:0] x);
    logic [OW-1:0] w;
    w = {{(OW-DW){1'b0}}, x};
    return (w * OW'(3)) + OW'(1);
  endfunction

  // Behavioural filter: fixed LAT-cycle pipeline
  logic [LAT-1:0] pv = '0;
  logic [OW-1:0]  pd [LAT];
  always @(posedge clk) begin
    if (fir_rst) begin
      pv <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], fir_valid_in};
      pd[0] <= f(fir_din);
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
  end
  assign fir_valid_out = pv[LAT-1] | force_vo;
  assign fir_dout      = pd[LAT-1];

  // Scoreboard and counters
  logic [OW-1:0] exp_q [$];
  int vec_cnt   = 0;
  int err_cnt   = 0;
  int acc_cnt   = 0;
  int out_cnt   = 0;
  int acc_total = 0;
  int out_total = 0;
  int fvi_cnt   = 0;
  int fvi_zero  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sampled on the falling edge: values are those the next rising edge sees.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_valid && s_ready) begin
        exp_q.push_back(f(s_data));
        acc_cnt++;
        acc_total++;
      end
      if (fir_valid_in) begin
        fvi_cnt++;
        if (fir_din == '0) fvi_zero++;
      end
      if (m_valid && m_ready) begin
        out_cnt++;
        out_total++;
        if (exp_q.size() == 0) check("sb_underflow", 64'(exp_q.size()), 64'd1);
        else check("m_data", 64'(m_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input logic [DW-1:0] base, output int stalls);
    stalls = 0;
    for (int k = 0; k < n; k++) begin
      s_valid = 1'b1;
      s_data  = base + DW'(k);
      @(negedge clk);
      while (!s_ready && stalls < 1000) begin
        stalls++;
        @(negedge clk);
      end
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic run_stream(input int cycles);
    logic a;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      a = s_valid && s_ready;
      tick();
      if (a) s_data = s_data + DW'(1);
    end
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    int st;

    rst_n = 1'b0; flush_req = 1'b0; s_valid = 1'b0; s_data = '0;
    m_ready = 1'b0; force_vo = 1'b0;

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fir_rst",   64'(fir_rst), 64'd1);
    check("rst_fvi",       64'(fir_valid_in), 64'd0);
    check("rst_fir_din",   64'(fir_din), 64'd0);
    check("rst_s_ready",   64'(s_ready), 64'd0);
    check("rst_m_valid",   64'(m_valid), 64'd0);
    check("rst_busy",      64'(busy), 64'd1);
    check("rst_overflow",  64'(overflow_err), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fir_rst) begin
        n++;
        if (s_ready || !busy) bad++;
      end
      if (m_valid || overflow_err) bad++;
    end
    check("init_len",      64'(n), 64'(RSTC));
    check("init_flags",    64'(bad), 64'd0);
    check("run_busy",      64'(busy), 64'd0);
    check("run_s_ready",   64'(s_ready), 64'd1);
    tick();

    // ---------------- streaming ----------------
    m_ready = 1'b1; acc_cnt = 0; out_cnt = 0;
    send(100, 16'h0000, st);
    check("stream_stalls", 64'(st), 64'd0);
    wait_empty("stream_drain");
    check("stream_out",    64'(out_cnt), 64'd100);
    check("stream_mvalid", 64'(m_valid), 64'd0);

    // ---------------- backpressure ----------------
    m_ready = 1'b0; acc_cnt = 0; out_cnt = 0;
    s_valid = 1'b1; s_data = 16'h0200;
    run_stream(60);
    @(negedge clk);
    check("bp_acc",        64'(acc_cnt), 64'(DEPTH));
    check("bp_s_ready",    64'(s_ready), 64'd0);
    check("bp_m_valid",    64'(m_valid), 64'd1);
    check("bp_overflow",   64'(overflow_err), 64'd0);
    tick();
    m_ready = 1'b1;
    run_stream(30);
    s_valid = 1'b0;
    check("bp_resume",     64'(acc_cnt > DEPTH), 64'd1);
    wait_empty("bp_drain");
    check("bp_out",        64'(out_cnt), 64'(acc_cnt));

    // ---------------- one-below-full credit, then concurrent traffic ----------------
    m_ready = 1'b0; acc_cnt = 0; out_cnt = 0;
    send(DEPTH - 1, 16'h0300, st);
    repeat (LAT + 4) tick();
    @(negedge clk);
    check("credit15_ready", 64'(s_ready), 64'd1);
    check("credit15_mv",    64'(m_valid), 64'd1);
    tick();
    m_ready = 1'b1; s_valid = 1'b1; s_data = 16'h0400;
    run_stream(40);
    s_valid = 1'b0;
    wait_empty("simul_drain");
    check("simul_out",     64'(out_cnt), 64'(acc_cnt));
    check("simul_overflow", 64'(overflow_err), 64'd0);

    // ---------------- flush ----------------
    m_ready = 1'b1; acc_cnt = 0; out_cnt = 0; fvi_cnt = 0; fvi_zero = 0;
    s_valid = 1'b1; s_data = 16'h8000;
    @(negedge clk);
    check("flush_pre_ready", 64'(s_ready), 64'd1);
    tick();
    s_valid = 1'b0; flush_req = 1'b1;
    for (int k = 0; k < TAPS; k++) exp_q.push_back(f('0));
    tick();
    flush_req = 1'b0;
    @(negedge clk);
    check("flush_busy",    64'(busy), 64'd1);
    check("flush_s_ready", 64'(s_ready), 64'd0);
    tick();
    repeat (4) tick();
    flush_req = 1'b1;   // must be ignored while flushing
    tick();
    flush_req = 1'b0;
    n = 0; bad = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      if (busy && s_ready) bad++;
      n++;
    end
    check("flush_done",    64'(busy), 64'd0);
    check("flush_ready_lo", 64'(bad), 64'd0);
    tick();
    wait_empty("flush_drain");
    check("flush_fvi",     64'(fvi_cnt), 64'(TAPS + 1));
    check("flush_zeros",   64'(fvi_zero), 64'(TAPS));
    check("flush_out",     64'(out_cnt), 64'(TAPS + 1));
    check("flush_run",     64'(s_ready), 64'd1);

    // ---------------- protocol error ----------------
    m_ready = 1'b0; out_cnt = 0;
    send(3, 16'h0500, st);
    repeat (LAT + 4) tick();
    @(negedge clk);
    check("err_pre",       64'(overflow_err), 64'd0);
    tick();
    force_vo = 1'b1;
    tick();
    force_vo = 1'b0;
    @(negedge clk);
    check("err_set",       64'(overflow_err), 64'd1);
    repeat (5) tick();
    @(negedge clk);
    check("err_sticky",    64'(overflow_err), 64'd1);
    tick();
    m_ready = 1'b1;
    wait_empty("err_drain");
    check("err_fifo_cnt",  64'(out_cnt), 64'd3);

`ifdef FIR_STREAM_STATS_EN
    check("stat_in",       64'(stat_in_cnt), 64'(acc_total));
    check("stat_out",      64'(stat_out_cnt), 64'(out_total));
`else
    check("stat_in_tied",  64'(stat_in_cnt), 64'd0);
    check("stat_out_tied", 64'(stat_out_cnt), 64'd0);
`endif

    // ---------------- reset mid-operation ----------------
    m_ready = 1'b0;
    send(2, 16'h0600, st);
    tick();
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst2_m_valid",  64'(m_valid), 64'd0);
    check("rst2_overflow", 64'(overflow_err), 64'd0);
    check("rst2_fir_rst",  64'(fir_rst), 64'd1);
    check("rst2_busy",     64'(busy), 64'd1);
    tick();
    acc_total = 0; out_total = 0;
    rst_n = 1'b1;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rst2_run",      64'(busy), 64'd0);
    tick();

    m_ready = 1'b1; out_cnt = 0;
    send(5, 16'h0700, st);
    wait_empty("post_rst_drain");
    check("post_rst_out",  64'(out_cnt), 64'd5);
    check("post_rst_err",  64'(overflow_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
